// File: rtl/dlk_mon_pkg.sv
// rtl/dlk_mon_pkg.sv - shared types and helpers for the deadlock watchdog
package dlk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dlk_state_e;

  localparam int DEFAULT_CNT_W = 16;

  // Counters up to 32 bits wide share this helper; callers cast to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dlk_stall_qualifier.sv
// rtl/dlk_stall_qualifier.sv - stall candidate detection and window counter
module dlk_stall_qualifier
  import dlk_mon_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int THRESH = 16,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_CH-1:0]  block_sigs,
  input  logic [N_CH-1:0]  idle_sigs,
  input  logic             freeze,
  output logic             cand,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             arm
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Every channel idle or blocked, and at least one genuinely blocked.
  assign cand = enable & (|block_sigs) & (&(block_sigs | idle_sigs));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!freeze) begin
      stall_cnt <= cand ? CNT_W'(sat_inc(32'(stall_cnt), 32'(CNT_MAX))) : '0;
    end
  end

  assign arm = cand && (stall_cnt == CNT_W'(THRESH - 1));

endmodule

// File: rtl/deadlock_watchdog_ctrl.sv
// rtl/deadlock_watchdog_ctrl.sv - qualifies kernel stalls, scans for the culprit
// channel round-robin and reports it over a valid/ready handshake
module deadlock_watchdog_ctrl
  import dlk_mon_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int THRESH = 16,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_CH-1:0]  block_sigs,
  input  logic [N_CH-1:0]  idle_sigs,
  output logic             kernel_block,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_chan,
  output logic [CNT_W-1:0] rpt_cycles,
  output logic [CNT_W-1:0] deadlock_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  dlk_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] steps_q, steps_d;
  logic [IDX_W-1:0] rpt_chan_q, rpt_chan_d;
  logic [CNT_W-1:0] rpt_cycles_q, rpt_cycles_d;
  logic [CNT_W-1:0] dl_count_q, dl_count_d;

  logic             cand;
  logic             arm;
  logic [CNT_W-1:0] stall_cnt;

  dlk_stall_qualifier #(
    .N_CH   (N_CH),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) u_qual (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .block_sigs (block_sigs),
    .idle_sigs  (idle_sigs),
    .freeze     (state_q == REPORT),
    .cand       (cand),
    .stall_cnt  (stall_cnt),
    .arm        (arm)
  );

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      scan_idx_q   <= '0;
      steps_q      <= '0;
      rpt_chan_q   <= '0;
      rpt_cycles_q <= '0;
      dl_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      scan_idx_q   <= scan_idx_d;
      steps_q      <= steps_d;
      rpt_chan_q   <= rpt_chan_d;
      rpt_cycles_q <= rpt_cycles_d;
      dl_count_q   <= dl_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    scan_idx_d   = scan_idx_q;
    steps_d      = steps_q;
    rpt_chan_d   = rpt_chan_q;
    rpt_cycles_d = rpt_cycles_q;
    dl_count_d   = dl_count_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = SCAN;
          scan_idx_d = rr_ptr_q;
          steps_d    = '0;
        end
      end
      SCAN: begin
        if (!cand) begin
          state_d = IDLE;
        end else if (block_sigs[scan_idx_q]) begin
          rpt_chan_d   = scan_idx_q;
          rpt_cycles_d = CNT_W'(sat_inc(32'(stall_cnt), 32'(CNT_MAX)));
          state_d      = REPORT;
        end else begin
          scan_idx_d = next_idx(scan_idx_q);
          // A full lap without a hit still counts as a deadlock, just unattributed.
          if (steps_q == LAST_IDX) begin
            state_d = HOLD;
          end else begin
            steps_d = steps_q + IDX_W'(1);
          end
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          dl_count_d = CNT_W'(sat_inc(32'(dl_count_q), 32'(CNT_MAX)));
          rr_ptr_d   = next_idx(rpt_chan_q);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!cand) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kernel_block   = (state_q != IDLE);
  assign rpt_valid      = (state_q == REPORT);
  assign rpt_chan       = rpt_chan_q;
  assign rpt_cycles     = rpt_cycles_q;
  assign deadlock_count = dl_count_q;

endmodule

// File: doc/deadlock_watchdog_ctrl.md
Name: deadlock_watchdog_ctrl

Overview:
Simulation-side controller that sequences deadlock detection for one HLS kernel.
- Watches per-channel block and idle flags (AXIS stream stalls, sub-instance idle/block).
- Qualifies a stall over a programmable window, then round-robin scans channels to pick the culprit.
- Reports the culprit through a valid/ready handshake to the bench reporter, and holds the kernel-block flag until the stall clears.
- Sits between the per-kernel monitor top and the testbench's $display/termination logic.

Parameters:
- N_CH, 3, number of monitored channels (AXIS block + instance block), ≥1
- THRESH, 16, consecutive stall cycles required before scan, ≥2
- CNT_W, 16, width of stall-cycle and deadlock counters (saturating)
- IDX_W, $clog2(N_CH) (min 1), channel index width

Ports:
- clock  in  1  kernel monitor clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  detection enable
- block_sigs  in  N_CH  per-channel blocked flag
- idle_sigs  in  N_CH  per-channel idle flag
- kernel_block  out  1  deadlock declared and not yet cleared
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_chan  out  IDX_W  index of blocked channel reported
- rpt_cycles  out  CNT_W  stall length in cycles at report time
- deadlock_count  out  CNT_W  number of accepted reports, saturating

Behaviour:
- Stall condition: cand = enable & (|block_sigs) & (&(block_sigs | idle_sigs)).
  - Every channel is idle or blocked, and at least one is blocked.
- Reset (reset=0, async):
  - state=IDLE, stall_cnt=0, rr_ptr=0, scan_idx=0.
  - All outputs 0.
- stall_cnt:
  - In any state except REPORT: increments (saturating at 2^CNT_W-1) when cand=1, clears to 0 when cand=0.
  - In REPORT: frozen.
- IDLE:
  - If cand=1 and stall_cnt==THRESH-1: go to SCAN, scan_idx=rr_ptr, steps=0.
  - Cand held from cycle 0 gives SCAN in cycle THRESH.
- SCAN, one channel per cycle:
  - kernel_block=1 from SCAN entry.
  - If cand=0: go to IDLE, kernel_block=0 next cycle, no report.
  - Else if block_sigs[scan_idx]=1: latch rpt_chan=scan_idx and rpt_cycles=stall_cnt+1 (saturating), go to REPORT.
  - Else: scan_idx = (scan_idx+1) mod N_CH (wrap N_CH-1→0), steps++.
  - If steps reaches N_CH with no hit: go to HOLD.
- REPORT:
  - rpt_valid=1. rpt_chan and rpt_cycles are stable while rpt_valid=1 and rpt_ready=0.
  - On rpt_valid & rpt_ready:
    - rpt_valid=0 next cycle.
    - deadlock_count++ (saturating).
    - rr_ptr = (rpt_chan+1) mod N_CH.
    - Go to HOLD.
  - Input changes, including cand dropping and enable=0, never abort REPORT. The handshake always completes.
- HOLD:
  - kernel_block=1.
  - When cand=0: go to IDLE, kernel_block=0 the following cycle.
  - A re-stall requires a fresh THRESH window from IDLE.
- enable=0 in IDLE/SCAN/HOLD:
  - Makes cand=0, so the FSM returns to IDLE through the rules above.
- rpt_chan and rpt_cycles keep their last values outside REPORT.
- Single-cycle rpt_ready pulses and ready-before-valid are both legal. Only the valid-cycle sample counts.
- Any glitch in cand during the window restarts counting from 0.
- Asserting reset mid-REPORT drops rpt_valid immediately. This is asynchronous.

Decomposition:
- Shared package dlk_mon_pkg holds:
  - state enum: IDLE, SCAN, REPORT, HOLD
  - default CNT_W
  - saturating-increment function
- One natural sub-module: dlk_stall_qualifier.
  - Computes cand and stall_cnt.
  - Asserts a one-cycle arm pulse at THRESH.
  - Controller FSM, round-robin pointer and report register stay in the top.

Test Plan (N_CH=3, THRESH=4, CNT_W=16):
- T1: enable=1, block_sigs=3'b010, idle_sigs=3'b101 from cycle 0, rpt_ready=1.
  - SCAN at cycle 4, kernel_block=1 at cycle 4.
  - Hit at idx1 in cycle 5, rpt_valid=1 cycle 6 with rpt_chan=1, rpt_cycles=6.
  - deadlock_count=1, then HOLD.
- T2: same as T1 but idle_sigs[0]=0 on cycle 2.
  - stall_cnt clears to 0, no SCAN until 4 further clean cycles.
  - kernel_block stays 0 throughout the glitch.
- T3: rpt_ready=0 for 10 cycles during REPORT, and cand dropped meanwhile.
  - rpt_valid, rpt_chan and rpt_cycles hold.
  - Accepted on ready, HOLD then IDLE the next cycle, kernel_block=0.
- T4: block_sigs=3'b101 stall twice, with cand cleared between.
  - First report rpt_chan=0, second report rpt_chan=2 (round-robin from rr_ptr=1).
  - deadlock_count=2.
- T5: all channels blocked, cand drops during SCAN before the hit is processed.
  - IDLE, no rpt_valid, kernel_block returns to 0.
- T6: reset asserted mid-REPORT with rpt_valid=1.
  - All outputs 0 asynchronously, deadlock_count=0, rr_ptr=0 after release.
